// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and the fetch stage.
package imem_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'hD503201F;

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x INSTR_W single-write, single-read synchronous RAM with a registered read port.
module imem_array #(
  parameter int unsigned DEPTH = 64,
  parameter logic [imem_pkg::INSTR_W-1:0] NOP_WORD = imem_pkg::NOP_WORD,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [imem_pkg::INSTR_W-1:0]  wdata,
  input  logic [AW-1:0]                 raddr,
  input  logic                          force_nop,
  output logic [imem_pkg::INSTR_W-1:0]  rdata
);
  import imem_pkg::*;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;
  logic [INSTR_W-1:0] rdata_d;

  // Image storage survives reset; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = NOP_WORD;
    if (!force_nop) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= NOP_WORD;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: boot-time load stream, then 1-cycle fetch reads
// with misaligned / out-of-image fault flags.
module imem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter logic [imem_pkg::INSTR_W-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [63:0]                   imem_addr_F,
  input  logic                          load_valid,
  input  logic [imem_pkg::INSTR_W-1:0]  load_data,
  input  logic                          load_last,
  output logic                          load_ready,
  output logic [imem_pkg::INSTR_W-1:0]  instr_F,
  output logic                          instr_valid,
  output logic                          misaligned,
  output logic                          out_of_range
);
  import imem_pkg::*;

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned IDX_W = 62;

  imem_state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] n_loaded_q, n_loaded_d;
  logic          instr_valid_q, instr_valid_d;
  logic          misaligned_q, misaligned_d;
  logic          oor_q, oor_d;
  logic          load_ready_q, load_ready_d;
  logic [IDX_W-1:0] idx;
  logic          mis_n;
  logic          oor_n;
  logic          we;
  logic          force_nop;

  // Next-state, pointer and fault logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    n_loaded_d    = n_loaded_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = 1'b0;
    oor_d         = 1'b0;
    we            = 1'b0;
    force_nop     = 1'b1;
    idx           = imem_addr_F[63:2];
    mis_n         = |imem_addr_F[1:0];
    // Full-width compare so huge addresses never alias into the image.
    oor_n         = (idx >= IDX_W'(n_loaded_q));
    case (state_q)
      IMEM_LOAD: begin
        if (load_valid) begin
          we         = 1'b1;
          wr_ptr_d   = wr_ptr_q + AW'(1);
          n_loaded_d = CW'(wr_ptr_q) + CW'(1);
          if (load_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
            state_d = IMEM_RUN;
          end
        end
      end
      IMEM_RUN: begin
        instr_valid_d = 1'b1;
        misaligned_d  = mis_n;
        oor_d         = oor_n;
        force_nop     = mis_n | oor_n;
      end
      default: state_d = IMEM_LOAD;
    endcase
    load_ready_d = (state_d == IMEM_LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IMEM_LOAD;
      wr_ptr_q      <= '0;
      n_loaded_q    <= '0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      oor_q         <= 1'b0;
      load_ready_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      n_loaded_q    <= n_loaded_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      oor_q         <= oor_d;
      load_ready_q  <= load_ready_d;
    end
  end

  imem_array #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_WORD)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .we        (we & ~reset),
    .waddr     (wr_ptr_q),
    .wdata     (load_data),
    .raddr     (idx[AW-1:0]),
    .force_nop (force_nop),
    .rdata     (instr_F)
  );

  assign load_ready   = load_ready_q;
  assign instr_valid  = instr_valid_q;
  assign misaligned   = misaligned_q;
  assign out_of_range = oor_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed load/fetch vectors, monitor pops per response.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'hD503201F;

  typedef struct {
    logic [31:0] instr;
    logic        mis;
    logic        oor;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr_F = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic [31:0] instr_F;
  logic        instr_valid;
  logic        misaligned;
  logic        out_of_range;

  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr_F  (imem_addr_F),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .instr_F      (instr_F),
    .instr_valid  (instr_valid),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_instr_F", 64'(instr_F), 64'(NOP));
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_misaligned", 64'(misaligned), 64'd0);
    chk("rst_out_of_range", 64'(out_of_range), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd1);
  endtask

  task automatic beat(input logic [31:0] data, input logic last, input logic exp_ready,
                      input logic run_push, input logic [31:0] run_word);
    exp_t e;
    chk("beat_load_ready", 64'(load_ready), 64'(exp_ready));
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    if (run_push) begin
      e.instr = run_word; e.mis = 1'b0; e.oor = 1'b0;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("idle_load_ready", 64'(load_ready), 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch(input logic [63:0] addr, input logic [31:0] instr,
                       input logic mis, input logic oor);
    exp_t e;
    imem_addr_F = addr;
    e.instr = instr; e.mis = mis; e.oor = oor;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      begin : stimulus
        // Four-word load with a three-cycle bubble before beat 3.
        do_reset();
        beat(32'h11111111, 1'b0, 1'b1, 1'b0, '0);
        beat(32'h22222222, 1'b0, 1'b1, 1'b0, '0);
        idle(3);
        beat(32'h33333333, 1'b0, 1'b1, 1'b0, '0);
        beat(32'h44444444, 1'b1, 1'b1, 1'b0, '0);
        chk("ready_after_last", 64'(load_ready), 64'd0);
        fetch(64'd0,  32'h11111111, 1'b0, 1'b0);
        fetch(64'd4,  32'h22222222, 1'b0, 1'b0);
        fetch(64'd8,  32'h33333333, 1'b0, 1'b0);
        fetch(64'd12, 32'h44444444, 1'b0, 1'b0);
        fetch(64'd16, NOP, 1'b0, 1'b1);
        fetch(64'hFFFF_FFFF_FFFF_FFF0, NOP, 1'b0, 1'b1);
        fetch(64'd6,  NOP, 1'b1, 1'b0);
        fetch(64'd18, NOP, 1'b1, 1'b1);
        fetch(64'd12, 32'h44444444, 1'b0, 1'b0);

        // Reset mid-RUN, reload two words; stale index 2 must be out of range.
        do_reset();
        beat(32'hAAAA0001, 1'b0, 1'b1, 1'b0, '0);
        beat(32'hBBBB0002, 1'b1, 1'b1, 1'b0, '0);
        fetch(64'd8, NOP, 1'b0, 1'b1);
        fetch(64'd4, 32'hBBBB0002, 1'b0, 1'b0);
        fetch(64'd0, 32'hAAAA0001, 1'b0, 1'b0);

        // Ten beats without load_last into an 8-deep array.
        do_reset();
        imem_addr_F = 64'd0;
        for (int i = 1; i <= 10; i++) begin
          beat(32'h80000000 + 32'(i), 1'b0, (i <= 8), (i > 8), 32'h80000001);
        end
        fetch(64'd28, 32'h80000008, 1'b0, 1'b0);
        fetch(64'd32, NOP, 1'b0, 1'b1);
        fetch(64'hFFFF_FFFF_FFFF_FFE0, NOP, 1'b0, 1'b1);
        fetch(64'd0, 32'h80000001, 1'b0, 1'b0);

        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("final_instr_valid", 64'(instr_valid), 64'd0);
        done = 1'b1;
      end
      begin : monitor
        exp_t e;
        while (!done) begin
          @(negedge clk);
          if (instr_valid === 1'b1) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_response actual instr=%h required=no response", instr_F);
            end else begin
              e = q.pop_front();
              chk("instr_F", 64'(instr_F), 64'(e.instr));
              chk("misaligned", 64'(misaligned), 64'(e.mis));
              chk("out_of_range", 64'(out_of_range), 64'(e.oor));
            end
          end
        end
      end
      begin : watchdog
        int cyc = 0;
        while (!done && cyc < 5000) begin
          @(posedge clk);
          cyc++;
        end
        if (!done) begin
          errors++;
          $display("FAIL watchdog actual=%0d cycles required=completion", cyc);
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $finish;
        end
      end
    join
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder at the far end of the fetch stage's `imem_addr_F` request. It holds the program image in an internal word array, which a boot-time load stream fills. Once the image is loaded, it returns the 32-bit instruction for each fetch address with one cycle of registered-read latency. It also flags misaligned and out-of-image fetches so the pipeline can trap them.

## Interface
Parameters:
- `DEPTH`, 64 — instruction words in the array; power of two, 2..1024.
- `NOP_WORD`, 32'hD503201F — word returned for faulting fetches and after reset.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `imem_addr_F`  in  64  — byte address from the fetch stage; sampled every cycle in RUN.
- `load_valid`  in  1  — load beat present.
- `load_data`  in  32  — instruction word for the current load beat.
- `load_last`  in  1  — marks the final load beat; qualified by `load_valid`.
- `load_ready`  out  1  — high in LOAD; a beat transfers when `load_valid && load_ready`.
- `instr_F`  out  32  — fetched instruction, registered.
- `instr_valid`  out  1  — `instr_F` holds a response to an address sampled in RUN.
- `misaligned`  out  1  — registered; the sampled address had `[1:0] != 0`.
- `out_of_range`  out  1  — registered; the sampled word index is at or above the loaded word count.

## Operation
- State machine with two states: LOAD and RUN. Reset enters LOAD.
- LOAD:
  - `load_ready`=1.
  - On each transfer, `mem[wr_ptr] <= load_data`, `wr_ptr++`, `n_loaded <= wr_ptr+1`.
  - Transition to RUN after a transfer with `load_last`=1, or after the transfer that writes index DEPTH-1, whichever comes first.
  - Beats with `load_valid`=0 are ignored; the state and pointers hold.
- RUN:
  - `load_ready`=0; `load_*` inputs are ignored.
  - Each cycle: `idx = imem_addr_F >> 2`.
  - `misaligned_n = |imem_addr_F[1:0]`.
  - `oor_n = (idx >= n_loaded)`, compared on the full 62-bit index; upper address bits are not truncated.
  - Next-cycle `instr_F` = `NOP_WORD` if `misaligned_n || oor_n`, else `mem[idx]`.
  - `misaligned` and `out_of_range` register `misaligned_n` and `oor_n`. Both may be 1 together.
- `n_loaded` range is 1..DEPTH. A load of zero beats is impossible, because LOAD only exits on a transfer.
- Array contents are not cleared by reset. Reset during RUN returns to LOAD and clears `wr_ptr` and `n_loaded`; the reload overwrites from index 0.
- Stale words at or above the new `n_loaded` are unreachable, because they are reported as out of range.

## Timing
- Reset values: `instr_F`=`NOP_WORD`, `instr_valid`=0, `misaligned`=0, `out_of_range`=0, `load_ready`=1, state=LOAD, `wr_ptr`=0, `n_loaded`=0.
- Load throughput: one word per cycle.
- Read latency: exactly 1 cycle. An address presented in cycle t produces `instr_F`, `misaligned` and `out_of_range` after edge t+1. Throughput is one fetch per cycle with no stall.
- `instr_valid` rises on the edge after the first RUN cycle, then stays high until reset.
- The final load transfer and the first RUN sample are in different cycles. The cycle after the last transfer is the first RUN cycle, so a read of the last-written index returns the new data.
- Reset asserted in any cycle wins over load and read in that cycle. Outputs take their reset values on that edge.
- Outputs depend only on registers; no combinational path from inputs to outputs.

## Structure
- Shared package `imem_pkg` holds:
  - `INSTR_W`=32;
  - the default `NOP_WORD`;
  - the state enum `imem_state_t {IMEM_LOAD, IMEM_RUN}`.
- The fetch stage imports the same package, so `NOP_WORD` matches the pipeline's bubble instruction.
- One sub-module is natural: `imem_array`, a DEPTH×32 single-write, single-read synchronous RAM with registered output.
  - The responder wraps it with the FSM, the pointers and the fault logic.
  - The fault flags are delayed one cycle to align with the RAM output.

## Test plan
- Load 4 words 0x11111111..0x44444444, last on beat 4:
  - `load_ready` drops the cycle after beat 4.
  - Addresses 0, 4, 8, 12 give those words one cycle later.
  - `instr_valid`=1 from the first response.
- After the 4-word load, address 16 -> `instr_F`=0xD503201F, `out_of_range`=1, `misaligned`=0. Address 0xFFFF_FFFF_FFFF_FFF0 -> the same result.
- Address 6 -> `NOP_WORD`, `misaligned`=1, `out_of_range`=0. Address 18 with 4 words loaded -> both flags 1.
- DEPTH=8, stream 10 beats with no `load_last`:
  - RUN is entered after beat 8; beats 9–10 see `load_ready`=0.
  - Address 28 returns beat 8's word; address 32 is out of range.
- Hold `load_valid` low for 3 cycles mid-load: no write, and `wr_ptr` holds. The resumed beat lands at the next index.
- Reset mid-RUN, then reload 2 words A and B:
  - During the reset cycle and reload, `instr_valid`=0.
  - After the reload, address 8 (stale from the earlier load) -> `NOP_WORD` with `out_of_range`=1. Address 4 -> B.
